// File: rtl/data_cache_ctrl_pkg.sv
// Shared constants, FSM encoding and halfword merge helper for the direct-mapped data cache.
package data_cache_ctrl_pkg;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int INDEX_W  = 3;
    localparam int OFFSET_W = 2;
    localparam int LINES    = 1 << INDEX_W;
    localparam int WORDS    = 1 << OFFSET_W;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W - 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REFILL = 2'd1,
        S_WRITE  = 2'd2
    } cache_state_t;

    // Big-endian halves: lo=0 replaces bits [31:16], lo=1 replaces bits [15:0].
    function automatic logic [DATA_W-1:0] merge_half(input logic [DATA_W-1:0] word,
                                                     input logic [15:0]       half,
                                                     input logic              lo);
        return lo ? {word[31:16], half} : {half, word[15:0]};
    endfunction

endpackage

// File: rtl/data_cache_ctrl_if.sv
// Datapath-side request signals and main-memory handshake of the data cache.
interface data_cache_ctrl_if;
    import data_cache_ctrl_pkg::*;

    logic                MemtoReg;
    logic                MemWrite;
    logic                ExtendLH;
    logic                ExtendSH;
    logic [ADDR_W-1:0]   cpu_addr;
    logic [DATA_W-1:0]   cpu_wdata;
    logic [DATA_W-1:0]   cpu_rdata;
    logic                stall;

    // Memory handshake: mem_read/mem_write is the request (valid), mem_ready completes the
    // beat on the rising edge where both are high; mem_addr/mem_wdata hold until then.
    logic                mem_read;
    logic                mem_write;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_ready;

    cache_state_t        dbg_state;

    modport slave (
        input  MemtoReg, MemWrite, ExtendLH, ExtendSH, cpu_addr, cpu_wdata,
        input  mem_rdata, mem_ready,
        output cpu_rdata, stall, mem_read, mem_write, mem_addr, mem_wdata, dbg_state
    );

    modport master (
        output MemtoReg, MemWrite, ExtendLH, ExtendSH, cpu_addr, cpu_wdata,
        output mem_rdata, mem_ready,
        input  cpu_rdata, stall, mem_read, mem_write, mem_addr, mem_wdata, dbg_state
    );

endinterface

// File: rtl/data_cache_ctrl_line_store.sv
// Valid/tag/data arrays of the cache: asynchronous read, one-word synchronous write.
module cache_line_store
    import data_cache_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [INDEX_W-1:0]  index,
    input  logic [OFFSET_W-1:0] rd_sel,
    output logic                rd_valid,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [DATA_W-1:0]   rd_word,
    input  logic                we,
    input  logic [OFFSET_W-1:0] wr_sel,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                inval,
    input  logic                set_valid,
    input  logic [TAG_W-1:0]    set_tag
);

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES][WORDS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (inval) begin
            valid_q[index] <= 1'b0;
        end else if (set_valid) begin
            valid_q[index] <= 1'b1;
        end
    end

    // Tag and data contents are meaningless without valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (set_valid) begin
            tag_q[index] <= set_tag;
        end
        if (we) begin
            data_q[index][wr_sel] <= wr_data;
        end
    end

    assign rd_valid = valid_q[index];
    assign rd_tag   = tag_q[index];
    assign rd_word  = data_q[index][rd_sel];

endmodule

// File: rtl/data_cache_ctrl.sv
// Direct-mapped write-through, write-allocate data cache: FSM, refill counter, lh/sh select and merge.
module data_cache_ctrl
    import data_cache_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    data_cache_ctrl_if.slave  bus
);

    cache_state_t        state, next_state;
    logic [OFFSET_W-1:0] cnt;

    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] word_sel;
    logic                rd_valid, hit, load_req;
    logic [TAG_W-1:0]    rd_tag;
    logic [DATA_W-1:0]   rd_word, store_word, load_word;
    logic [15:0]         rd_half;
    logic                unused_byte_bit;

    logic                we, inval, set_valid;
    logic [OFFSET_W-1:0] wr_sel;
    logic [DATA_W-1:0]   wr_data;
    logic                stall_c, mem_read_c, mem_write_c;
    logic [ADDR_W-1:0]   mem_addr_c;
    logic [DATA_W-1:0]   mem_wdata_c;

    assign tag             = bus.cpu_addr[ADDR_W-1 -: TAG_W];
    assign index           = bus.cpu_addr[OFFSET_W+2 +: INDEX_W];
    assign word_sel        = bus.cpu_addr[2 +: OFFSET_W];
    assign unused_byte_bit = bus.cpu_addr[0];

    cache_line_store u_store (
        .clk       (clk),
        .rst       (rst),
        .index     (index),
        .rd_sel    (word_sel),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_word   (rd_word),
        .we        (we),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .inval     (inval),
        .set_valid (set_valid),
        .set_tag   (tag)
    );

    // A simultaneous load+store request is treated as a store.
    assign load_req   = bus.MemtoReg && !bus.MemWrite;
    assign hit        = rd_valid && (rd_tag == tag);
    assign store_word = bus.ExtendSH ? merge_half(rd_word, bus.cpu_wdata[15:0], bus.cpu_addr[1])
                                     : bus.cpu_wdata;
    assign rd_half    = bus.cpu_addr[1] ? rd_word[15:0] : rd_word[31:16];
    assign load_word  = bus.ExtendLH ? {{16{rd_half[15]}}, rd_half} : rd_word;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (state == S_REFILL && bus.mem_ready) begin
                cnt <= cnt + 2'd1;
            end
        end
    end

    always_comb begin
        next_state  = state;
        stall_c     = 1'b0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        we          = 1'b0;
        wr_sel      = word_sel;
        wr_data     = store_word;
        inval       = 1'b0;
        set_valid   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.MemWrite) begin
                    stall_c = 1'b1;
                    if (hit) begin
                        we         = 1'b1;
                        next_state = S_WRITE;
                    end else begin
                        inval      = 1'b1;
                        next_state = S_REFILL;
                    end
                end else if (load_req && !hit) begin
                    stall_c    = 1'b1;
                    inval      = 1'b1;
                    next_state = S_REFILL;
                end
            end
            S_REFILL: begin
                stall_c    = 1'b1;
                mem_read_c = 1'b1;
                mem_addr_c = {tag, index, cnt, 2'b00};
                if (bus.mem_ready) begin
                    we      = 1'b1;
                    wr_sel  = cnt;
                    wr_data = bus.mem_rdata;
                    if (cnt == 2'd3) begin
                        set_valid  = 1'b1;
                        next_state = S_IDLE;
                    end
                end
            end
            S_WRITE: begin
                // The line already holds the merged word, so write-through reads it back.
                mem_write_c = 1'b1;
                mem_addr_c  = {bus.cpu_addr[ADDR_W-1:2], 2'b00};
                mem_wdata_c = rd_word;
                stall_c     = !bus.mem_ready;
                if (bus.mem_ready) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    assign bus.stall     = rst && stall_c;
    assign bus.mem_read  = rst && mem_read_c;
    assign bus.mem_write = rst && mem_write_c;
    assign bus.mem_addr  = rst ? mem_addr_c  : '0;
    assign bus.mem_wdata = rst ? mem_wdata_c : '0;
    assign bus.cpu_rdata = rst ? load_word   : '0;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Directed bench for data_cache_ctrl: memory responder, request driver and traffic scoreboard.
module tb_data_cache_ctrl;
  import data_cache_ctrl_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_cache_ctrl_if bus();

  data_cache_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [128];
  logic [31:0] exp_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  bit          ready_phase;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // memory responder: ready every other cycle of an active request, logs accepted beats
  always @(negedge clk) begin
    if (rst && (bus.mem_read || bus.mem_write)) begin
      bus.mem_ready = ready_phase;
      ready_phase   = !ready_phase;
      bus.mem_rdata = bus.mem_read ? mem[bus.mem_addr[8:2]] : 32'h0;
      if (bus.mem_ready) begin
        if (bus.mem_read) rd_q.push_back(bus.mem_addr);
        if (bus.mem_write) begin
          wa_q.push_back(bus.mem_addr);
          wd_q.push_back(bus.mem_wdata);
          mem[bus.mem_addr[8:2]] = bus.mem_wdata;
        end
      end
    end else begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'h0;
      ready_phase   = 1'b0;
    end
  end

  task automatic drive(input bit ld, input bit st, input bit lh, input bit sh,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.MemtoReg  = ld;
    bus.MemWrite  = st;
    bus.ExtendLH  = lh;
    bus.ExtendSH  = sh;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
  endtask

  // issue one request, hold it until stall drops, return first-cycle stall and load data
  task automatic do_req(input string tag, input bit ld, input bit st, input bit lh, input bit sh,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output bit stalled, output logic [31:0] rdata);
    int cycles;
    @(negedge clk);
    rd_q.delete();
    wa_q.delete();
    wd_q.delete();
    drive(ld, st, lh, sh, addr, wdata);
    #1;
    stalled = bus.stall;
    cycles  = 0;
    while (bus.stall && cycles < 200) begin
      @(negedge clk);
      #1;
      cycles++;
    end
    check_eq({tag, " stall released"}, {31'd0, bus.stall}, 32'd0);
    rdata = bus.cpu_rdata;
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic check_beats(input string tag, input int n, input logic [31:0] base);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
    check_eq({tag, " beat count"}, 32'(rd_q.size()), 32'(n));
    for (int i = 0; i < n && i < rd_q.size(); i++)
      check_eq({tag, " beat addr"}, rd_q[i], exp_q[i]);
  endtask

  initial begin
    bit          stalled;
    logic [31:0] rdata;
    int          cycles;

    for (int i = 0; i < 128; i++) mem[i] = 32'hA000_0000 + 32'(i * 4);
    mem[32'h100 >> 2] = 32'h1111_2222;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0);

    // reset with a miss request present: every output must be gated to zero
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst stall",     {31'd0, bus.stall},     32'd0);
    check_eq("rst mem_read",  {31'd0, bus.mem_read},  32'd0);
    check_eq("rst mem_write", {31'd0, bus.mem_write}, 32'd0);
    check_eq("rst mem_addr",  bus.mem_addr,           32'd0);
    check_eq("rst mem_wdata", bus.mem_wdata,          32'd0);
    check_eq("rst cpu_rdata", bus.cpu_rdata,          32'd0);
    check_eq("rst state",     32'(bus.dbg_state),     32'(S_IDLE));
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;

    // 1: cold load miss refills the whole line
    do_req("t1 lw 0x40", 1, 0, 0, 0, 32'h40, 32'h0, stalled, rdata);
    check_eq("t1 first stall", {31'd0, stalled}, 32'd1);
    check_beats("t1", 4, 32'h40);
    check_eq("t1 rdata", rdata, 32'hA000_0040);
    check_eq("t1 writes", 32'(wa_q.size()), 32'd0);

    // 2: hit in the refilled line
    do_req("t2 lw 0x44", 1, 0, 0, 0, 32'h44, 32'h0, stalled, rdata);
    check_eq("t2 first stall", {31'd0, stalled}, 32'd0);
    check_eq("t2 rdata", rdata, 32'hA000_0044);
    check_eq("t2 reads", 32'(rd_q.size()), 32'd0);
    check_eq("t2 writes", 32'(wa_q.size()), 32'd0);

    // 3: store hit writes through, then reads back from the cache
    do_req("t3 sw 0x48", 0, 1, 0, 0, 32'h48, 32'hDEAD_BEEF, stalled, rdata);
    check_eq("t3 first stall", {31'd0, stalled}, 32'd1);
    check_eq("t3 reads", 32'(rd_q.size()), 32'd0);
    check_eq("t3 writes", 32'(wa_q.size()), 32'd1);
    if (wa_q.size() > 0) begin
      check_eq("t3 wr addr", wa_q[0], 32'h48);
      check_eq("t3 wr data", wd_q[0], 32'hDEAD_BEEF);
    end
    do_req("t3 lw 0x48", 1, 0, 0, 0, 32'h48, 32'h0, stalled, rdata);
    check_eq("t3 lw stall", {31'd0, stalled}, 32'd0);
    check_eq("t3 lw rdata", rdata, 32'hDEAD_BEEF);

    // 4: halfword loads with sign extension, big-endian halves
    do_req("t4 sw 0x48", 0, 1, 0, 0, 32'h48, 32'h8001_1234, stalled, rdata);
    do_req("t4 lh 0x48", 1, 0, 1, 0, 32'h48, 32'h0, stalled, rdata);
    check_eq("t4 lh hi stall", {31'd0, stalled}, 32'd0);
    check_eq("t4 lh hi rdata", rdata, 32'hFFFF_8001);
    check_eq("t4 lh hi traffic", 32'(rd_q.size() + wa_q.size()), 32'd0);
    do_req("t4 lh 0x4A", 1, 0, 1, 0, 32'h4A, 32'h0, stalled, rdata);
    check_eq("t4 lh lo stall", {31'd0, stalled}, 32'd0);
    check_eq("t4 lh lo rdata", rdata, 32'h0000_1234);
    check_eq("t4 lh lo traffic", 32'(rd_q.size() + wa_q.size()), 32'd0);

    // 5: halfword store miss allocates, merges low half, writes full word through
    do_req("t5 sh 0x102", 0, 1, 0, 1, 32'h102, 32'h0000_ABCD, stalled, rdata);
    check_eq("t5 first stall", {31'd0, stalled}, 32'd1);
    check_beats("t5", 4, 32'h100);
    check_eq("t5 writes", 32'(wa_q.size()), 32'd1);
    if (wa_q.size() > 0) begin
      check_eq("t5 wr addr", wa_q[0], 32'h100);
      check_eq("t5 wr data", wd_q[0], 32'h1111_ABCD);
    end
    do_req("t5 lw 0x100", 1, 0, 0, 0, 32'h100, 32'h0, stalled, rdata);
    check_eq("t5 lw stall", {31'd0, stalled}, 32'd0);
    check_eq("t5 lw rdata", rdata, 32'h1111_ABCD);

    // 6: conflicting miss interrupted by reset mid-refill
    @(negedge clk);
    rd_q.delete();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'hC0, 32'h0);
    cycles = 0;
    while (rd_q.size() < 2 && cycles < 100) begin
      @(negedge clk);
      #1;
      cycles++;
    end
    check_eq("t6 beats before rst", {31'd0, rd_q.size() >= 2}, 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_eq("t6 rst mem_read", {31'd0, bus.mem_read}, 32'd0);
    check_eq("t6 rst stall",    {31'd0, bus.stall},    32'd0);
    check_eq("t6 rst mem_addr", bus.mem_addr,          32'd0);
    check_eq("t6 rst state",    32'(bus.dbg_state),    32'(S_IDLE));
    repeat (2) @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    do_req("t6 lw 0x40", 1, 0, 0, 0, 32'h40, 32'h0, stalled, rdata);
    check_eq("t6 lw first stall", {31'd0, stalled}, 32'd1);
    check_beats("t6", 4, 32'h40);
    check_eq("t6 lw rdata", rdata, 32'hA000_0040);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
